// File: rtl/prom_loader_pkg.sv
// Shared constants and state encoding for the downloadable 256x4 PROM loader.
package prom_loader_pkg;

    localparam int PROM_DEPTH   = 256;
    localparam int PROM_WIDTH   = 4;
    localparam int PROM_ADDR_W  = 8;
    localparam int SUM_W        = 12;
    localparam int IOCTL_ADDR_W = 25;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD   = 3'd1;
    localparam state_t ST_VERIFY = 3'd2;
    localparam state_t ST_DONE   = 3'd3;
    localparam state_t ST_ERR    = 3'd4;

endpackage

// File: rtl/prom_ram_256x4.sv
// Single-port 256x4 RAM with registered read data; clr zeroes the output register only.
module prom_ram_256x4
    import prom_loader_pkg::*;
(
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   en,
    input  logic                   we,
    input  logic [PROM_ADDR_W-1:0] addr,
    input  logic [PROM_WIDTH-1:0]  wdata,
    output logic [PROM_WIDTH-1:0]  rdata
);

    logic [PROM_WIDTH-1:0] mem [PROM_DEPTH];
    logic [PROM_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
        if (clr) begin
            rdata_q <= '0;
        end else if (en) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/prom_nibble_loader.sv
// Loads a 256x4 PROM image from the ioctl byte stream, checksum-verifies it,
// then serves 1-cycle registered reads; dout is forced to 0 until the image is good.
module prom_nibble_loader
    import prom_loader_pkg::*;
#(
    parameter logic [7:0]              ROM_INDEX    = 8'd0,
    parameter logic [IOCTL_ADDR_W-1:0] BASE_ADDR    = 25'h0,
    parameter logic [SUM_W-1:0]        EXPECTED_SUM = 12'h000,
    parameter bit                      CHECK_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    input  logic [7:0]  addr,
    input  logic        cs,
    output logic [3:0]  dout,
    output logic        load_done,
    output logic        load_err
);

    state_t                  state_q, state_d;
    logic [PROM_DEPTH-1:0]   bitmap_q, bitmap_d;
    logic [SUM_W-1:0]        sum_q, sum_d;
    logic [PROM_ADDR_W-1:0]  vcnt_q, vcnt_d;
    logic                    rd_vld_q, rd_vld_d;
    logic                    cmp_q, cmp_d;
    logic                    wait_q, wait_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    rd_own_q, rd_own_d;

    logic                    dl_match, in_win, wr_acc, verify_rd;
    logic [IOCTL_ADDR_W-1:0] win_off;
    logic [SUM_W-1:0]        sum_total;

    logic                    ram_clr, ram_en, ram_we;
    logic [PROM_ADDR_W-1:0]  ram_addr;
    logic [PROM_WIDTH-1:0]   ram_rdata;
    logic                    unused_dout_hi;

    assign unused_dout_hi = ^ioctl_dout[7:4];

    always_comb begin
        dl_match  = ioctl_download && (ioctl_index == ROM_INDEX);
        win_off   = ioctl_addr - BASE_ADDR;
        in_win    = (ioctl_addr >= BASE_ADDR) && (win_off[IOCTL_ADDR_W-1:PROM_ADDR_W] == '0);
        wr_acc    = (state_q == ST_LOAD) && dl_match && ioctl_wr && in_win;
        // The last sweep cycle is the compare slot: no read issued, last nibble folded in combinationally.
        verify_rd = (state_q == ST_VERIFY) && !cmp_q;
        sum_total = sum_q + {{(SUM_W-PROM_WIDTH){1'b0}}, ram_rdata};

        state_d  = state_q;
        bitmap_d = bitmap_q;
        sum_d    = sum_q;

        if (wr_acc) begin
            bitmap_d[win_off[PROM_ADDR_W-1:0]] = 1'b1;
        end
        if ((state_q == ST_VERIFY) && rd_vld_q) begin
            sum_d = sum_total;
        end

        case (state_q)
            ST_IDLE: begin
                if (dl_match) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (!ioctl_download) begin
                    if (!(&bitmap_q))  state_d = ST_ERR;
                    else if (CHECK_EN) state_d = ST_VERIFY;
                    else               state_d = ST_DONE;
                end
            end
            ST_VERIFY: begin
                if (cmp_q) state_d = (sum_total == EXPECTED_SUM) ? ST_DONE : ST_ERR;
            end
            ST_DONE, ST_ERR: begin
                if (dl_match) state_d = ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_q != ST_LOAD) && (state_d == ST_LOAD)) begin
            bitmap_d = '0;
            sum_d    = '0;
        end

        vcnt_d   = verify_rd ? vcnt_q + 8'd1 : 8'd0;
        rd_vld_d = verify_rd;
        cmp_d    = verify_rd && (vcnt_q == 8'hFF);
        wait_d   = wr_acc;
        done_d   = (state_d == ST_DONE);
        err_d    = (state_d == ST_ERR);
        // dout only follows the RAM for edges that stay in DONE, so a reload start never shows old data.
        rd_own_d = (state_q == ST_DONE) && (state_d == ST_DONE);

        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = addr;
        case (state_q)
            ST_LOAD: begin
                ram_en   = wr_acc;
                ram_we   = wr_acc;
                ram_addr = win_off[PROM_ADDR_W-1:0];
            end
            ST_VERIFY: begin
                ram_en   = verify_rd;
                ram_addr = vcnt_q;
            end
            ST_DONE: ram_en = cs;
            default: ram_en = 1'b0;
        endcase
        ram_clr = reset || !((state_q == ST_DONE) || verify_rd);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            bitmap_q <= '0;
            sum_q    <= '0;
            vcnt_q   <= '0;
            rd_vld_q <= 1'b0;
            cmp_q    <= 1'b0;
            wait_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rd_own_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitmap_q <= bitmap_d;
            sum_q    <= sum_d;
            vcnt_q   <= vcnt_d;
            rd_vld_q <= rd_vld_d;
            cmp_q    <= cmp_d;
            wait_q   <= wait_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rd_own_q <= rd_own_d;
        end
    end

    prom_ram_256x4 u_ram (
        .clk   (clk),
        .clr   (ram_clr),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ioctl_dout[3:0]),
        .rdata (ram_rdata)
    );

    assign dout       = rd_own_q ? ram_rdata : 4'h0;
    assign ioctl_wait = wait_q;
    assign load_done  = done_q;
    assign load_err   = err_q;

endmodule

// File: tb/tb_prom_nibble_loader.sv
// Directed bench: dut_a (base 0, good sum) and dut_b (base 0x100, wrong sum) share one ioctl bus.
module tb_prom_nibble_loader;

    logic        clk = 1'b0;
    logic        reset, ioctl_download, ioctl_wr, cs;
    logic [7:0]  ioctl_index, ioctl_dout, addr;
    logic [24:0] ioctl_addr;
    logic        wait_a, done_a, err_a, wait_b, done_b, err_b;
    logic [3:0]  dout_a, dout_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    prom_nibble_loader #(
        .ROM_INDEX(8'd0), .BASE_ADDR(25'h0), .EXPECTED_SUM(12'h780), .CHECK_EN(1'b1)
    ) dut_a (
        .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(wait_a),
        .addr(addr), .cs(cs), .dout(dout_a), .load_done(done_a), .load_err(err_a)
    );

    prom_nibble_loader #(
        .ROM_INDEX(8'd0), .BASE_ADDR(25'h100), .EXPECTED_SUM(12'h781), .CHECK_EN(1'b1)
    ) dut_b (
        .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(wait_b),
        .addr(addr), .cs(cs), .dout(dout_b), .load_done(done_b), .load_err(err_b)
    );

    typedef struct {
        logic [7:0] a;
        logic [3:0] exp_orig;
        logic [3:0] exp_inv;
    } rd_vec_t;

    rd_vec_t rv [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_wait(input logic [24:0] a, input logic [24:0] base);
        return (ioctl_index == 8'd0) && (a >= base) && (a < base + 25'd256);
    endfunction

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        tick();
        check("wait_a", wait_a, exp_wait(a, 25'h0));
        check("wait_b", wait_b, exp_wait(a, 25'h100));
        check("dout_a_loading", dout_a, 0);
        ioctl_wr = 1'b0;
        tick();
        check("wait_a_drop", wait_a, 0);
        check("wait_b_drop", wait_b, 0);
    endtask

    task automatic dl_start(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick();
    endtask

    task automatic dl_body(input logic [24:0] base, input int skip, input bit inv);
        for (int i = 0; i < 256; i++) begin
            if (i != skip) wr_byte(base + 25'(i), inv ? 8'(255 - i) : 8'(i));
        end
        ioctl_download = 1'b0;
    endtask

    // mode 0: original image, 1: inverted image, 2: reads must return 0
    task automatic read_table(input int mode);
        logic [3:0] e;
        for (int i = 0; i < 8; i++) begin
            e = (mode == 0) ? rv[i].exp_orig : (mode == 1) ? rv[i].exp_inv : 4'h0;
            addr = rv[i].a;
            cs   = 1'b1;
            tick();
            check("read_a", dout_a, e);
            check("read_b_zero", dout_b, 0);
            addr = ~rv[i].a;
            cs   = 1'b0;
            tick();
            check("hold_a", dout_a, e);
        end
    endtask

    initial begin
        int n;
        rv[0] = '{8'h3A, 4'hA, 4'h5};
        rv[1] = '{8'h00, 4'h0, 4'hF};
        rv[2] = '{8'hFF, 4'hF, 4'h0};
        rv[3] = '{8'h05, 4'h5, 4'hA};
        rv[4] = '{8'h7F, 4'hF, 4'h0};
        rv[5] = '{8'h80, 4'h0, 4'hF};
        rv[6] = '{8'hC3, 4'h3, 4'hC};
        rv[7] = '{8'h1E, 4'hE, 4'h1};

        reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; cs = 1'b0;
        ioctl_index = 8'd0; ioctl_dout = 8'd0; ioctl_addr = 25'd0; addr = 8'd0;
        tick();
        tick();
        reset = 1'b0;
        addr = 8'h05;
        cs   = 1'b1;
        tick();
        check("rst_dout", dout_a, 0);
        check("rst_done", done_a, 0);
        check("rst_err", err_a, 0);
        check("rst_wait", wait_a, 0);

        // Full image data=addr: 256 reads + compare after the LOAD exit edge
        dl_start(8'd0);
        dl_body(25'h0, -1, 1'b0);
        tick();
        check("b_incomplete_err", err_b, 1);
        check("a_verifying_err", err_a, 0);
        n = 1;
        while (!done_a && !err_a && n < 400) begin
            tick();
            n++;
        end
        check("verify_cycles", n, 258);
        check("load_done", done_a, 1);
        check("load_err_clear", err_a, 0);
        read_table(0);

        // Reload with inverted nibbles (same sum)
        addr = 8'h3A;
        cs   = 1'b1;
        dl_start(8'd0);
        check("reload_done_drop", done_a, 0);
        check("reload_dout_zero", dout_a, 0);
        dl_body(25'h0, -1, 1'b1);
        n = 0;
        while (!done_a && !err_a && n < 400) begin
            tick();
            n++;
        end
        check("reload_verify_cycles", n, 258);
        check("reload_done", done_a, 1);
        read_table(1);

        // Image missing entry 0x7F goes straight to ERR
        dl_start(8'd0);
        dl_body(25'h0, 8'h7F, 1'b1);
        tick();
        check("omit_err", err_a, 1);
        check("omit_done", done_a, 0);
        cs   = 1'b1;
        addr = 8'h3A;
        tick();
        check("omit_dout", dout_a, 0);

        // dut_b: out-of-window bytes, back-to-back writes, checksum mismatch
        dl_start(8'd0);
        wr_byte(25'h0FF, 8'h0F);
        wr_byte(25'h200, 8'h0F);
        for (int i = 0; i < 256; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'h100 + 25'(i);
            ioctl_dout = 8'(i);
            tick();
            check("b2b_wait_b", wait_b, 1);
            check("b2b_wait_a", wait_a, 0);
        end
        ioctl_wr = 1'b0;
        tick();
        check("b2b_wait_end", wait_b, 0);
        ioctl_download = 1'b0;
        tick();
        check("a_partial_err", err_a, 1);
        check("b_verifying", err_b, 0);
        n = 1;
        while (!done_b && !err_b && n < 400) begin
            tick();
            n++;
        end
        check("b_verify_cycles", n, 258);
        check("b_sum_err", err_b, 1);
        check("b_sum_done", done_b, 0);
        cs = 1'b1;
        for (int i = 0; i < 256; i++) begin
            addr = 8'(i);
            tick();
            check("b_err_dout", dout_b, 0);
        end

        // Reset at VERIFY cycle 100
        dl_start(8'd0);
        dl_body(25'h0, -1, 1'b0);
        tick();
        repeat (100) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midverify_done", done_a, 0);
        check("midverify_err", err_a, 0);
        repeat (300) tick();
        check("midverify_stays_idle", done_a, 0);
        addr = 8'h3A;
        cs   = 1'b1;
        tick();
        check("midverify_dout", dout_a, 0);

        // Non-matching index is ignored
        dl_start(8'h55);
        for (int i = 0; i < 4; i++) wr_byte(25'(i), 8'h0A);
        ioctl_download = 1'b0;
        repeat (300) tick();
        check("foreign_done", done_a, 0);
        check("foreign_err_a", err_a, 0);
        check("foreign_err_b", err_b, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

endmodule
